// File: rtl/mem_access_unit.sv
// mem_access_unit -- RV32I memory stage.
//
// Turns one load/store request from the execute stage into at most one
// word-aligned transfer on a valid/ack data bus and returns exactly one
// response per accepted request.
//
// Handshakes:
//   Request side : a request transfers on a cycle where req_valid & req_ready
//                  are both high; req_ready is high only in IDLE, and the
//                  upstream holds its request until it is taken.
//   Bus side     : bus_req stays high with bus_we/addr/wdata/be stable until
//                  a cycle with bus_ack or bus_err (bus_err wins), or until
//                  the wait-cycle timeout expires.
//   Response     : resp_valid is a one-cycle strobe with no back-pressure.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    request from the execute stage
//   resp_*                   response strobe, load data, rd, writeback, error
//   bus_*                    data bus master side
//   dbg_state                current FSM state (0 IDLE, 1 BUS, 2 RESP)
//
// resp_err: 00 ok, 01 misaligned, 10 bus fault/timeout, 11 illegal funct3.

module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_we,
  output logic [1:0]  resp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_load_q, is_load_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic        resp_we_q, resp_we_d;
  logic [1:0]  resp_err_q, resp_err_d;

  // Request decode
  logic        is_mem;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_rep;

  always_comb begin
    is_mem  = req_is_load | req_is_store;
    illegal = 1'b0;
    if (req_is_load)
      illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    else if (req_is_store)
      illegal = (req_funct3 >= 3'd3);
    misaligned = is_mem &&
                 (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
    case (req_funct3[1:0])
      2'b00: begin
        req_be        = 4'b0001 << req_addr[1:0];
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be        = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata;
      end
    endcase
  end

  // Load data extraction from the live bus word, using the latched address
  // low bits and funct3 of the transaction in flight.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    case (addr_lo_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  // Timeout fires on the cycle that would be the TIMEOUT-th uncompleted
  // BUS cycle, so bus_req is high for exactly TIMEOUT cycles.
  logic timeout;
  assign timeout = (TIMEOUT != 0) && !bus_ack && !bus_err && ((cnt_q + 16'd1) == TMO);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    is_load_d    = is_load_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    resp_we_d    = resp_we_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_lo_d = req_addr[1:0];
          funct3_d  = req_funct3;
          is_load_d = req_is_load;
          resp_rd_d = req_rd;
          if (is_mem && !illegal && !misaligned) begin
            state_d     = BUS;
            cnt_d       = 16'd0;
            bus_req_d   = 1'b1;
            bus_we_d    = req_is_store;
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_wdata_d = req_wdata_rep;
            bus_be_d    = req_be;
          end else begin
            // Checks failed, or not a memory op: answer without the bus.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_we_d    = 1'b0;
            resp_rdata_d = 32'd0;
            resp_err_d   = illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);
          end
        end
      end
      BUS: begin
        if (bus_err || timeout) begin
          state_d      = RESP;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_we_d    = 1'b0;
          resp_rdata_d = 32'd0;
          resp_err_d   = 2'b10;
        end else if (bus_ack) begin
          state_d      = RESP;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 2'b00;
          resp_we_d    = is_load_q && (resp_rd_q != 5'd0);
          resp_rdata_d = (is_load_q && (resp_rd_q != 5'd0)) ? ld_ext : 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        state_d      = IDLE;
        resp_we_d    = 1'b0;
        resp_rdata_d = 32'd0;
        resp_err_d   = 2'b00;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      addr_lo_q    <= 2'd0;
      funct3_q     <= 3'd0;
      is_load_q    <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_wdata_q  <= 32'd0;
      bus_be_q     <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_rd_q    <= 5'd0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
      is_load_q    <= is_load_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      resp_we_q    <= resp_we_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;
  assign resp_we    = resp_we_q;
  assign resp_err   = resp_err_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = bus_be_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases plus a randomized loop.
// Responses are checked by a scoreboard monitor against an expected queue.

module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_load, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_we;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // {rdata[31:0], rd[4:0], we, err[1:0]}
  logic [39:0] exp_q[$];

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_we(resp_we), .resp_err(resp_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("resp_unexpected", 64'd1, 64'd0);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check_eq("resp_rdata", {32'd0, resp_rdata}, {32'd0, e[39:8]});
        check_eq("resp_rd",    {59'd0, resp_rd},    {59'd0, e[7:3]});
        check_eq("resp_we",    {63'd0, resp_we},    {63'd0, e[2]});
        check_eq("resp_err",   {62'd0, resp_err},   {62'd0, e[1:0]});
      end
    end
  end

  // Reference model from the ISA definition of loads and store lanes.
  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] one;
    one = 4'b0001;
    if (f3[1:0] == 2'b00) return one << lo;
    if (f3[1:0] == 2'b01) return lo[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (f3[1:0] == 2'b00) return {4{w[7:0]}};
    if (f3[1:0] == 2'b01) return {2{w[15:0]}};
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> (lo * 8);
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return d;
    endcase
  endfunction

  // Driver: called at a negedge with the DUT idle. respond=0 means never
  // answer (timeout). exp_* give the required bus and response values.
  task automatic mem_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input logic use_bus, input logic respond, input int waits,
                        input logic give_err, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata, input logic exp_we, input logic [1:0] exp_err);
    check_eq("ready_before", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_is_load = ld; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    exp_q.push_back({exp_rdata, rd, exp_we, exp_err});
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (!use_bus) begin
      check_eq("nobus_req", {63'd0, bus_req}, 64'd0);
      check_eq("nobus_lat1", {63'd0, resp_valid}, 64'd1);
    end else begin
      for (int i = 0; i < 64; i++) begin
        check_eq("bus_req", {63'd0, bus_req}, 64'd1);
        check_eq("bus_we", {63'd0, bus_we}, {63'd0, st});
        check_eq("bus_addr", {32'd0, bus_addr}, {32'd0, addr[31:2], 2'b00});
        check_eq("bus_be", {60'd0, bus_be}, {60'd0, exp_be});
        if (st) check_eq("bus_wdata", {32'd0, bus_wdata}, {32'd0, exp_wdata});
        if (respond && i == waits) begin
          bus_ack = !give_err; bus_err = give_err; bus_rdata = rdata;
          @(negedge clk);
          bus_ack = 1'b0; bus_err = 1'b0;
          break;
        end
        if (!respond && i == TMO - 1) begin
          @(negedge clk);
          break;
        end
        @(negedge clk);
      end
      check_eq("bus_req_off", {63'd0, bus_req}, 64'd0);
      check_eq("resp_lat", {63'd0, resp_valid}, 64'd1);
    end
    @(negedge clk);
    check_eq("ready_after", {63'd0, req_ready}, 64'd1);
    check_eq("resp_one_cycle", {63'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
    repeat (3) @(negedge clk);
    // Reset state
    check_eq("rst_ready", {63'd0, req_ready}, 64'd1);
    check_eq("rst_state", {62'd0, dbg_state}, 64'd0);
    check_eq("rst_outs", {resp_valid, resp_we, resp_err, resp_rd, bus_req, bus_we, bus_be},
             64'd0);
    check_eq("rst_data", {resp_rdata, bus_addr}, 64'd0);
    check_eq("rst_wdata", {32'd0, bus_wdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Stray ack while idle is ignored
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check_eq("idle_ack_req", {63'd0, bus_req}, 64'd0);
    check_eq("idle_ack_resp", {63'd0, resp_valid}, 64'd0);

    // SB 0x1003
    mem_op(0, 1, 3'd0, 32'h1003, 32'h000000A5, 5'd5, 1, 1, 0, 0, 32'h0,
           4'b1000, 32'hA5A5A5A5, 32'h0, 0, 2'b00);
    // LB / LBU 0x2001
    mem_op(1, 0, 3'd0, 32'h2001, 32'h0, 5'd7, 1, 1, 0, 0, 32'h123480FF,
           4'b0010, 32'h0, 32'hFFFFFF80, 1, 2'b00);
    mem_op(1, 0, 3'd4, 32'h2001, 32'h0, 5'd7, 1, 1, 0, 0, 32'h123480FF,
           4'b0010, 32'h0, 32'h00000080, 1, 2'b00);
    // Misaligned LW, illegal load funct3, illegal store funct3, non-mem op
    mem_op(1, 0, 3'd2, 32'h2002, 32'h0, 5'd3, 0, 0, 0, 0, 32'h0,
           4'b0, 32'h0, 32'h0, 0, 2'b01);
    mem_op(1, 0, 3'd3, 32'h0, 32'h0, 5'd3, 0, 0, 0, 0, 32'h0,
           4'b0, 32'h0, 32'h0, 0, 2'b11);
    mem_op(0, 1, 3'd3, 32'h1, 32'h0, 5'd4, 0, 0, 0, 0, 32'h0,
           4'b0, 32'h0, 32'h0, 0, 2'b11);
    mem_op(0, 0, 3'd2, 32'h40, 32'h0, 5'd9, 0, 0, 0, 0, 32'h0,
           4'b0, 32'h0, 32'h0, 0, 2'b00);
    // LH with 3 wait cycles, both halves
    mem_op(1, 0, 3'd1, 32'h10, 32'h0, 5'd8, 1, 1, 3, 0, 32'h80017FFF,
           4'b0011, 32'h0, 32'h00007FFF, 1, 2'b00);
    mem_op(1, 0, 3'd1, 32'h12, 32'h0, 5'd8, 1, 1, 0, 0, 32'h80017FFF,
           4'b1100, 32'h0, 32'hFFFF8001, 1, 2'b00);
    // Timeout, bus_err on a store, load to x0
    mem_op(1, 0, 3'd2, 32'h300, 32'h0, 5'd6, 1, 0, 0, 0, 32'h0,
           4'b1111, 32'h0, 32'h0, 0, 2'b10);
    mem_op(0, 1, 3'd2, 32'h304, 32'hDEADBEEF, 5'd6, 1, 1, 1, 1, 32'h0,
           4'b1111, 32'hDEADBEEF, 32'h0, 0, 2'b10);
    mem_op(1, 0, 3'd2, 32'h308, 32'h0, 5'd0, 1, 1, 0, 0, 32'hCAFEF00D,
           4'b1111, 32'h0, 32'h0, 0, 2'b00);
    // SH upper half
    mem_op(0, 1, 3'd1, 32'h402, 32'h1234ABCD, 5'd1, 1, 1, 0, 0, 32'h0,
           4'b1100, 32'hABCDABCD, 32'h0, 0, 2'b00);

    // Reset during BUS, then a late ack
    req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h100; req_rd = 5'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("rstbus_req", {63'd0, bus_req}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus_ack = 1'b1;
    check_eq("rstbus_req_off", {63'd0, bus_req}, 64'd0);
    check_eq("rstbus_ready", {63'd0, req_ready}, 64'd1);
    check_eq("rstbus_noresp", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    check_eq("late_ack_noresp", {63'd0, resp_valid}, 64'd0);
    check_eq("late_ack_nobus", {63'd0, bus_req}, 64'd0);
    mem_op(1, 0, 3'd2, 32'h0, 32'h0, 5'd31, 1, 1, 0, 0, 32'h87654321,
           4'b1111, 32'h0, 32'h87654321, 1, 2'b00);

    // Randomized legal, aligned operations
    for (int n = 0; n < 30; n++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a, w, d;
      logic [4:0]  rd;
      int          wt, k;
      st = 1'($urandom_range(0, 1));
      k  = $urandom_range(0, st ? 2 : 4);
      case (k)
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd2;
        3: f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      a = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      w  = $urandom;
      d  = $urandom;
      rd = 5'($urandom_range(0, 31));
      wt = $urandom_range(0, 2);
      mem_op(!st, st, f3, a, w, rd, 1, 1, wt, 0, d,
             model_be(f3, a[1:0]), model_wdata(f3, w),
             (!st && rd != 0) ? model_load(f3, a[1:0], d) : 32'h0,
             !st && rd != 0, 2'b00);
    end

    repeat (2) @(negedge clk);
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the RV32I core. Sits directly downstream of the execute-stage arithmetic unit and consumes its 32-bit result as the effective address for loads and stores.
- Converts LB/LH/LW/LBU/LHU/SB/SH/SW into single word-aligned transactions on a valid/ack data bus. Generates byte enables, replicates store data across lanes, and sign- or zero-extends load data.
- Reports one response per request, including misalignment, illegal-width and bus-fault errors.

Parameters:
TIMEOUT, 255, bus wait cycles before a bus fault is raised; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  memory op presented by the execute stage
req_ready  out  1  unit can accept a request (high only in IDLE)
req_is_load  in  1  op is a load
req_is_store  in  1  op is a store (never both with req_is_load)
req_funct3  in  3  RV32I width/sign field
req_addr  in  32  effective address from the execute-stage result
req_wdata  in  32  store data (rs2)
req_rd  in  5  load destination register
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_rd  out  5  destination echoed from the request
resp_we  out  1  register writeback enable
resp_err  out  2  00 ok, 01 misaligned, 10 bus fault, 11 illegal funct3
bus_req  out  1  bus request
bus_we  out  1  1 = write
bus_addr  out  32  word-aligned address, {req_addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_be  out  4  byte enables
bus_ack  in  1  bus completes transfer this cycle
bus_rdata  in  32  read data, valid with bus_ack
bus_err  in  1  bus completes transfer with an error this cycle

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - State = IDLE, so req_ready = 1.
  - All other outputs = 0.
  - Timeout counter = 0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Accept when req_valid & req_ready. Latch addr, funct3, wdata, rd, and op type.
- Checks on accept, in priority order:
  - Illegal funct3 → err 11. Illegal for loads: 3, 6, 7. Illegal for stores: ≥ 3.
  - Misaligned → err 01. Halfword with addr[0] = 1; word with addr[1:0] ≠ 0.
  - Neither load nor store → err 00, no bus access.
  - Any of the three cases above goes to RESP with no bus activity.
  - Otherwise go to BUS.
- BUS:
  - bus_req = 1. bus_we, bus_addr, bus_wdata and bus_be are registered and held stable until completion.
  - Completion on bus_ack or bus_err; bus_err wins if both are asserted.
  - On bus_ack, latch bus_rdata.
  - Timeout counter increments each BUS cycle without completion. When it reaches TIMEOUT (TIMEOUT > 0), treat as bus_err.
  - On completion or timeout, go to RESP. bus_req is low from the RESP cycle onward.
- Byte enables:
  - SB: be = 1 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - SW: be = 1111.
  - Loads use the same be pattern for their width, with bus_we = 0.
- Load extraction:
  - LB/LBU: byte lane addr[1:0], sign- or zero-extended.
  - LH/LHU: half lane addr[1], sign- or zero-extended.
  - LW: full word.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - resp_we = 1 only for a load with err 00 and rd ≠ 0.
  - resp_rdata = 0 unless resp_we = 1.
  - resp_rd always echoes the latched rd.
- Latency:
  - Handshake in cycle 0.
  - Bus access: bus_req in cycle 1. With a zero-wait ack, resp_valid in cycle 2 and req_ready in cycle 3.
  - Fault or no-bus case: resp_valid in cycle 1.
- Boundary conditions:
  - bus_ack or bus_err while not in BUS: ignored.
  - req_valid while not ready: not accepted; upstream holds the request.
  - rst in any state: next cycle IDLE, bus_req = 0, no resp_valid. A pending transaction is abandoned, and its late ack is ignored.
  - The timeout counter clears on every entry to BUS.

Test Plan:
- SB, addr 0x1003, wdata 0x000000A5, ack in first BUS cycle → bus_addr 0x1000, be 1000, wdata 0xA5A5A5A5, we 1; resp_valid next cycle with err 00, resp_we 0, resp_rdata 0.
- LB addr 0x2001, bus_rdata 0x123480FF → resp_rdata 0xFFFFFF80, resp_we 1; LBU, same stimulus → 0x00000080.
- LW addr 0x2002 → no bus_req ever; resp_valid in cycle 1 with err 01, resp_we 0. Load with funct3 = 3 → err 11.
- LH addr 0x10, ack after 3 wait cycles, bus_rdata 0x80017FFF → bus outputs constant for all 4 BUS cycles, resp_rdata 0x00007FFF; LH addr 0x12 with the same data → 0xFFFF8001.
- TIMEOUT = 4, load with no ack → bus_req high for exactly 4 cycles, then resp err 10, resp_we 0, req_ready back high.
- rst during BUS, then a bus_ack pulse one cycle later → bus_req 0 and req_ready 1 after the reset edge; no resp_valid; a following LW to 0x0 completes normally.
